// File: rtl/uart_tx_msg_arb.sv
// uart_tx_msg_arb
// Message-level round-robin arbiter in front of the UART transmit character
// FIFO. One requester owns the FIFO write port for a whole message, so bytes
// of different messages never interleave on the serial line.
//
// Handshake: a byte moves from requester i to the FIFO on a clk_tx edge where
// req_valid[i] and req_ready[i] are both high. A requester that raises
// req_valid keeps it high, with req_data/req_last stable, until that edge.
// req_ready never depends on req_valid, only on grant and char_fifo_full.
//
// The FSM state is observable on `busy` (high exactly in XFER).

module uart_tx_msg_arb #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_tx,
    input  logic                 rst_clk_tx_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 char_fifo_full,
    output logic                 char_fifo_wr_en,
    output logic [7:0]           char_fifo_din,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 msg_abort
);

    // Index width for a requester number (NUM_REQ is at least 2).
    localparam int IDX_W = $clog2(NUM_REQ);
    // Timeout counter width; kept at one bit when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] IDX_RESET  = IDX_W'(NUM_REQ - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYC > 0);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]         state_q;
    logic [0:0]         state_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [IDX_W-1:0]   last_idx_q;
    logic [IDX_W-1:0]   last_idx_d;
    logic [CNT_W-1:0]   to_cnt_q;
    logic [CNT_W-1:0]   to_cnt_d;
    logic [CNT_W-1:0]   to_cnt_inc;
    logic               msg_abort_d;

    // Granted-lane view of the requester inputs.
    logic               g_valid;
    logic               g_last;
    logic [7:0]         g_data;

    // Arbitration result.
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    // Handshake and timeout qualifiers.
    logic               accept;
    logic               idle_tick;
    logic               to_hit;

    // Granted lane: grant is one-hot or zero, so an OR-mux is sufficient.
    always_comb begin
        g_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_data = g_data | req_data[8*i +: 8];
            end
        end
    end

    assign g_valid = |(req_valid & grant);
    assign g_last  = |(req_last & grant);

    // FIFO-side outputs follow the registered grant; zero when nothing is granted.
    assign req_ready       = grant & {NUM_REQ{~char_fifo_full}};
    assign char_fifo_wr_en = g_valid & ~char_fifo_full;
    assign char_fifo_din   = g_data;
    assign busy            = (state_q == ST_XFER);

    assign accept     = char_fifo_wr_en;
    // Only a missing byte counts toward the timeout; a byte held off by a
    // full FIFO does not.
    assign idle_tick  = busy & ~g_valid;
    assign to_cnt_inc = to_cnt_q + CNT_W'(1);
    assign to_hit     = TIMEOUT_EN && idle_tick && (to_cnt_inc == CNT_LIMIT);

    // Rotating-priority scan starting just after the last granted requester.
    always_comb begin
        logic [IDX_W-1:0] cand_idx;
        int               cand;
        pick_found  = 1'b0;
        pick_idx    = last_idx_q;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_idx_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    // Next-state logic: grant a whole message, release on last or timeout.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant;
        last_idx_d  = last_idx_q;
        to_cnt_d    = to_cnt_q;
        msg_abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_XFER;
                    grant_d    = pick_onehot;
                    last_idx_d = pick_idx;
                    to_cnt_d   = '0;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    to_cnt_d = '0;
                    if (g_last) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (to_hit) begin
                    // last_idx is left on the aborted requester so it
                    // drops to lowest priority in the next arbitration.
                    msg_abort_d = 1'b1;
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    to_cnt_d    = '0;
                end else if (TIMEOUT_EN && idle_tick) begin
                    to_cnt_d = to_cnt_inc;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                to_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset gives requester 0 first priority.
    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            state_q    <= ST_IDLE;
            grant      <= '0;
            last_idx_q <= IDX_RESET;
            to_cnt_q   <= '0;
            msg_abort  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant      <= grant_d;
            last_idx_q <= last_idx_d;
            to_cnt_q   <= to_cnt_d;
            msg_abort  <= msg_abort_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_msg_arb.sv
// tb_uart_tx_msg_arb
// Bench for uart_tx_msg_arb (NUM_REQ=3, TIMEOUT_CYC=8). Requesters replay
// byte queues; a message-level model predicts the outputs every cycle.

module tb_uart_tx_msg_arb;

    localparam int N  = 3;
    localparam int TO = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] gap;
    } item_t;

    // ---------------- clock / reset ----------------
    logic clk_tx       = 1'b0;
    logic rst_clk_tx_n = 1'b0;

    always #5 clk_tx = ~clk_tx;

    logic [N-1:0]   req_valid      = '0;
    logic [8*N-1:0] req_data       = '0;
    logic [N-1:0]   req_last       = '0;
    logic [N-1:0]   req_ready;
    logic           char_fifo_full = 1'b0;
    logic           char_fifo_wr_en;
    logic [7:0]     char_fifo_din;
    logic [N-1:0]   grant;
    logic           busy;
    logic           msg_abort;

    uart_tx_msg_arb #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk_tx          (clk_tx),
        .rst_clk_tx_n    (rst_clk_tx_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .char_fifo_full  (char_fifo_full),
        .char_fifo_wr_en (char_fifo_wr_en),
        .char_fifo_din   (char_fifo_din),
        .grant           (grant),
        .busy            (busy),
        .msg_abort       (msg_abort)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    item_t      src_q[N][$];
    int         gap_left[N];
    bit         loaded[N];
    bit         acc_s[N];
    int         full_pct   = 0;
    bit         full_force = 1'b0;

    // Message-level model: who owns the FIFO, who was granted last, how long
    // the owner has been silent, and whether an abort is being reported.
    int         m_owner = -1;
    int         m_last  = N - 1;
    int         m_idle  = 0;
    bit         m_abort = 1'b0;

    logic [7:0] exp_q[$];
    int         grant_log[$];
    int         grant_cyc[$];
    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    int         abort_cnt = 0;

    logic [N-1:0]   prev_grant = '0;
    logic [N-1:0]   prev_pend  = '0;
    logic [8*N-1:0] prev_data  = '0;
    logic [N-1:0]   prev_lastv = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int wr_at(input int k);
        return (k < wr_log.size()) ? int'(wr_log[k]) : -1;
    endfunction

    function automatic int wc_at(input int k);
        return (k < wr_cyc.size()) ? wr_cyc[k] : -1000;
    endfunction

    function automatic int gr_at(input int k);
        return (k < grant_log.size()) ? grant_log[k] : -1;
    endfunction

    // ---------------- requester / FIFO driver ----------------
    always @(posedge clk_tx) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && acc_s[i] && rst_clk_tx_n) begin
                void'(src_q[i].pop_front());
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                loaded[i]    = 1'b0;
            end
            if (!req_valid[i] && src_q[i].size() > 0) begin
                if (!loaded[i]) begin
                    gap_left[i] = int'(src_q[i][0].gap);
                    loaded[i]   = 1'b1;
                end
                if (gap_left[i] == 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = src_q[i][0].data;
                    req_last[i]         = src_q[i][0].last;
                end else begin
                    gap_left[i]--;
                end
            end
        end
        char_fifo_full = full_force || (int'($urandom_range(0, 99)) < full_pct);
    end

    task automatic push_byte(input int r, input logic [7:0] d, input logic l, input int gap);
        item_t it;
        it.data = d;
        it.last = l;
        it.gap  = 8'(gap);
        src_q[r].push_back(it);
    endtask

    // ---------------- compare process + model + scoreboard ----------------
    always @(negedge clk_tx) begin
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ready;
        logic         exp_wr;
        logic [7:0]   exp_b;
        bit           found;
        int           cand;
        cyc++;
        if (!rst_clk_tx_n) begin
            m_owner = -1;
            m_last  = N - 1;
            m_idle  = 0;
            m_abort = 1'b0;
            exp_q.delete();
            chk("reset_grant", 32'(grant), 32'd0);
            chk("reset_ready", 32'(req_ready), 32'd0);
            chk("reset_wr_en", 32'(char_fifo_wr_en), 32'd0);
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_abort", 32'(msg_abort), 32'd0);
            for (int i = 0; i < N; i++) acc_s[i] = 1'b0;
            prev_pend  = '0;
            prev_grant = '0;
        end else begin
            exp_grant = '0;
            exp_ready = '0;
            exp_wr    = 1'b0;
            if (m_owner >= 0) begin
                exp_grant[m_owner] = 1'b1;
                exp_ready[m_owner] = !char_fifo_full;
                exp_wr             = req_valid[m_owner] && !char_fifo_full;
            end
            chk("grant", 32'(grant), 32'(exp_grant));
            chk("busy", 32'(busy), 32'(m_owner >= 0));
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("wr_en", 32'(char_fifo_wr_en), 32'(exp_wr));
            chk("msg_abort", 32'(msg_abort), 32'(m_abort));
            if (m_owner >= 0) begin
                chk("din", 32'(char_fifo_din), 32'(req_data[8*m_owner +: 8]));
            end

            // Scoreboard of bytes that must reach the FIFO, in order.
            if (exp_wr) exp_q.push_back(req_data[8*m_owner +: 8]);
            if (char_fifo_wr_en) begin
                wr_log.push_back(char_fifo_din);
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("fifo_unexpected_write", 32'd1, 32'd0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("fifo_byte", 32'(char_fifo_din), 32'(exp_b));
                end
            end

            if (grant != '0 && prev_grant == '0) begin
                grant_log.push_back(onehot_idx(grant));
                grant_cyc.push_back(cyc);
            end
            if (msg_abort) abort_cnt++;

            // Requester obligations: hold valid/data/last until accepted.
            for (int i = 0; i < N; i++) begin
                if (prev_pend[i]) begin
                    chk("hold_valid", 32'(req_valid[i]), 32'd1);
                    chk("hold_data", 32'(req_data[8*i +: 8]), 32'(prev_data[8*i +: 8]));
                    chk("hold_last", 32'(req_last[i]), 32'(prev_lastv[i]));
                end
                acc_s[i] = req_valid[i] && req_ready[i];
            end
            prev_pend  = req_valid & ~req_ready;
            prev_data  = req_data;
            prev_lastv = req_last;
            prev_grant = grant;

            // Advance the model across the coming edge.
            m_abort = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    cand = (m_last + k) % N;
                    if (!found && req_valid[cand]) begin
                        found   = 1'b1;
                        m_owner = cand;
                        m_last  = cand;
                        m_idle  = 0;
                    end
                end
            end else if (exp_wr) begin
                m_idle = 0;
                if (req_last[m_owner]) m_owner = -1;
            end else if (!req_valid[m_owner]) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_abort = 1'b1;
                    m_owner = -1;
                    m_idle  = 0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_logs();
        grant_log.delete();
        grant_cyc.delete();
        wr_log.delete();
        wr_cyc.delete();
    endtask

    task automatic apply_reset();
        @(posedge clk_tx);
        #3 rst_clk_tx_n = 1'b0;
        repeat (2) @(posedge clk_tx);
        #3 rst_clk_tx_n = 1'b1;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n;
        bit pend;
        n    = 0;
        pend = 1'b1;
        while (pend && n < budget) begin
            @(negedge clk_tx);
            #1;
            n++;
            pend = (req_valid != '0) || (m_owner >= 0);
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() != 0) pend = 1'b1;
            end
        end
        chk({name, "_done"}, 32'(pend), 32'd0);
        chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_wr(input string name, input int count, input int budget);
        int n;
        n = 0;
        while (wr_log.size() < count && n < budget) begin
            @(negedge clk_tx);
            #1;
            n++;
        end
        chk({name, "_reached"}, 32'(wr_log.size() >= count), 32'd1);
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] g, input int budget);
        int n;
        n = 0;
        while (grant !== g && n < budget) begin
            @(negedge clk_tx);
            #1;
            n++;
        end
        chk({name, "_granted"}, 32'(grant), 32'(g));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- directed + random tests ----------------
    initial begin
        int base_abort;
        rst_clk_tx_n = 1'b0;
        repeat (3) @(posedge clk_tx);
        #3 rst_clk_tx_n = 1'b1;
        @(negedge clk_tx);
        #1;
        chk("post_reset_grant", 32'(grant), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_wr_en", 32'(char_fifo_wr_en), 32'd0);

        // Single requester: "OK\r\n" from req1.
        clear_logs();
        push_byte(1, 8'h4F, 1'b0, 0);
        push_byte(1, 8'h4B, 1'b0, 0);
        push_byte(1, 8'h0D, 1'b0, 0);
        push_byte(1, 8'h0A, 1'b1, 0);
        wait_quiet("single", 200);
        chk("single_grant_cnt", 32'(grant_log.size()), 32'd1);
        chk("single_grant_idx", 32'(gr_at(0)), 32'd1);
        chk("single_b0", 32'(wr_at(0)), 32'h4F);
        chk("single_b1", 32'(wr_at(1)), 32'h4B);
        chk("single_b2", 32'(wr_at(2)), 32'h0D);
        chk("single_b3", 32'(wr_at(3)), 32'h0A);
        chk("single_first_write_at_grant", 32'(wc_at(0)), 32'(grant_cyc.size() > 0 ? grant_cyc[0] : -1));
        chk("single_back_to_back", 32'(wc_at(3) - wc_at(0)), 32'd3);
        chk("single_end_grant", 32'(grant), 32'd0);
        chk("single_end_busy", 32'(busy), 32'd0);

        // Contention: three 3-byte messages offered together after reset.
        apply_reset();
        clear_logs();
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < 3; j++) begin
                push_byte(r, 8'(8'h30 + 16 * r + j), (j == 2), 0);
            end
        end
        wait_quiet("contend", 300);
        for (int k = 0; k < 3; k++) chk("contend_order", 32'(gr_at(k)), 32'(k));
        for (int k = 0; k < 9; k++) chk("contend_byte", 32'(wr_at(k)), 32'(8'h30 + 16 * (k / 3) + (k % 3)));
        for (int k = 1; k < 9; k++) chk("contend_spacing", 32'(wc_at(k) - wc_at(k - 1)), (k % 3 == 0) ? 32'd2 : 32'd1);

        // Rotation: req0 and req2 keep re-requesting single-byte messages.
        clear_logs();
        for (int m = 0; m < 6; m++) begin
            push_byte(0, 8'(8'hA0 + m), 1'b1, 0);
            push_byte(2, 8'(8'hC0 + m), 1'b1, 0);
        end
        wait_quiet("rotate", 300);
        chk("rotate_grant_cnt", 32'(grant_log.size()), 32'd12);
        for (int k = 0; k < 12; k++) chk("rotate_order", 32'(gr_at(k)), (k % 2 == 0) ? 32'd0 : 32'd2);

        // Backpressure: FIFO full for longer than the timeout mid-message.
        clear_logs();
        base_abort = abort_cnt;
        for (int j = 0; j < 6; j++) push_byte(1, 8'(8'h50 + j), (j == 5), 0);
        wait_wr("bp", 2, 100);
        full_force = 1'b1;
        repeat (12) @(posedge clk_tx);
        full_force = 1'b0;
        wait_quiet("bp", 300);
        chk("bp_no_abort", 32'(abort_cnt - base_abort), 32'd0);
        chk("bp_byte_cnt", 32'(wr_log.size()), 32'd6);
        for (int k = 0; k < 6; k++) chk("bp_byte", 32'(wr_at(k)), 32'(8'h50 + k));
        chk("bp_stall_len", 32'(wc_at(2) - wc_at(1)), 32'd12);

        // Timeout: req1 goes silent for TO cycles mid-message, req2 waiting.
        clear_logs();
        base_abort = abort_cnt;
        push_byte(1, 8'h61, 1'b0, 0);
        push_byte(1, 8'h62, 1'b1, TO);
        wait_grant("to_req1", 3'b010, 50);
        push_byte(2, 8'h71, 1'b0, 0);
        push_byte(2, 8'h72, 1'b1, 0);
        wait_quiet("to", 300);
        chk("to_abort_cnt", 32'(abort_cnt - base_abort), 32'd1);
        chk("to_grant0", 32'(gr_at(0)), 32'd1);
        chk("to_grant1", 32'(gr_at(1)), 32'd2);
        chk("to_grant2", 32'(gr_at(2)), 32'd1);
        chk("to_byte0", 32'(wr_at(0)), 32'h61);
        chk("to_byte1", 32'(wr_at(1)), 32'h71);
        chk("to_byte2", 32'(wr_at(2)), 32'h72);
        chk("to_byte3", 32'(wr_at(3)), 32'h62);

        // Asynchronous reset during byte 2 of a req2 message.
        clear_logs();
        for (int j = 0; j < 5; j++) push_byte(2, 8'(8'h81 + j), (j == 4), 0);
        wait_wr("arst", 2, 100);
        #2 rst_clk_tx_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_wr_en", 32'(char_fifo_wr_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        push_byte(0, 8'h91, 1'b0, 0);
        push_byte(0, 8'h92, 1'b1, 0);
        clear_logs();
        repeat (2) @(posedge clk_tx);
        #3 rst_clk_tx_n = 1'b1;
        wait_quiet("arst", 300);
        chk("arst_first_grant", 32'(gr_at(0)), 32'd0);
        chk("arst_second_grant", 32'(gr_at(1)), 32'd2);
        chk("arst_b0", 32'(wr_at(0)), 32'h91);
        chk("arst_b1", 32'(wr_at(1)), 32'h92);
        for (int k = 0; k < 4; k++) chk("arst_resume", 32'(wr_at(2 + k)), 32'(8'h82 + k));

        // Random traffic with random FIFO backpressure and occasional long gaps.
        clear_logs();
        full_pct = 25;
        for (int m = 0; m < 60; m++) begin
            int r;
            int len;
            int gap;
            r   = int'($urandom_range(0, N - 1));
            len = int'($urandom_range(1, 5));
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 9) < 8) gap = int'($urandom_range(0, 2));
                else gap = int'($urandom_range(TO - 1, TO + 1));
                push_byte(r, 8'($urandom), (j == len - 1), gap);
            end
        end
        wait_quiet("random", 20000);
        full_pct = 0;
        repeat (3) @(posedge clk_tx);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
